// File: rtl/team_id_pkg.sv
`default_nettype none
// ============================================================================
// Module   : team_id_pkg
// Purpose  : Shared register offsets, bit indices and FSM encoding for the
//            team ID reader peripheral.
// Revision : 1.0 - initial release
// ============================================================================
package team_id_pkg;

  // Byte offsets of the four registers inside the 8-byte window
  localparam logic [3:0] c_OFF_ID   = 4'h0;
  localparam logic [3:0] c_OFF_STAT = 4'h2;
  localparam logic [3:0] c_OFF_CTRL = 4'h4;
  localparam logic [3:0] c_OFF_RAW  = 4'h6;

  // STAT bit positions
  localparam int c_STAT_VALID = 0;
  localparam int c_STAT_CHG   = 1;
  localparam int c_STAT_BUSY  = 2;

  // CTRL bit positions
  localparam int c_CTRL_EN = 0;
  localparam int c_CTRL_IE = 1;

  // Debounce FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_WAIT_STABLE = 2'd1,
    ST_LOCKED      = 2'd2
  } state_t;

  // The bus carries word addresses, so a byte offset maps to its word index
  function automatic logic [1:0] reg_idx(input logic [3:0] off);
    return off[2:1];
  endfunction

endpackage
`default_nettype wire

// File: rtl/team_id_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : team_id_reader_if
// Purpose  : Peripheral bus bundle (address, data, enables, read data).
// Revision : 1.0 - initial release
// ============================================================================
interface team_id_reader_if;
  logic [13:0] per_addr;
  logic [15:0] per_din;
  logic        per_en;
  logic [1:0]  per_we;
  logic [15:0] per_dout;

  modport master (
    output per_addr, per_din, per_en, per_we,
    input  per_dout
  );

  modport slave (
    input  per_addr, per_din, per_en, per_we,
    output per_dout
  );
endinterface
`default_nettype wire

// File: rtl/team_id_sync.sv
`default_nettype none
// ============================================================================
// Module   : team_id_sync
// Purpose  : Two-flop synchronizer for the asynchronous team ID bus.
// Revision : 1.0 - initial release
// ============================================================================
module team_id_sync #(
  parameter int WIDTH = 16
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic [WIDTH-1:0] i_d,
  output logic      [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;

  // Two back-to-back stages to settle metastability on the incoming bus
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

endmodule
`default_nettype wire

// File: rtl/team_id_reader.sv
`default_nettype none
// ============================================================================
// Module   : team_id_reader
// Purpose  : Memory-mapped peripheral that synchronizes and debounces a
//            16-bit team ID bus, latches stable values and flags changes.
// Revision : 1.0 - initial release
// ============================================================================
module team_id_reader
  import team_id_pkg::*;
#(
  parameter logic [14:0] BASE_ADDR  = 15'h01B8,
  parameter int          DEC_WD     = 3,
  parameter int          STABLE_CNT = 4
) (
  input  wire logic              mclk,
  input  wire logic              puc_rst_n,
  team_id_reader_if.slave        per,
  input  wire logic              smclk_en,
  input  wire logic [15:0]       team_id_in,
  output logic                   irq
);

  localparam logic [1:0] c_IDX_ID   = reg_idx(c_OFF_ID);
  localparam logic [1:0] c_IDX_STAT = reg_idx(c_OFF_STAT);
  localparam logic [1:0] c_IDX_CTRL = reg_idx(c_OFF_CTRL);
  localparam logic [1:0] c_IDX_RAW  = reg_idx(c_OFF_RAW);
  localparam logic [7:0] c_CNT_LAST = 8'(STABLE_CNT - 1);

  // Registers
  state_t      r_state;
  logic [15:0] r_cand;
  logic [7:0]  r_cnt;
  logic [15:0] r_id;
  logic        r_valid;
  logic        r_chg;
  logic        r_ctrl_en;
  logic        r_ctrl_ie;

  // Combinational
  logic [15:0] w_raw;
  logic        w_sel;
  logic        w_rd;
  logic        w_wr_lo;
  logic [1:0]  w_idx;
  logic        w_busy;
  logic        w_latch;
  logic        w_chg_set;
  logic        w_chg_clr;
  logic        w_ctrl_wr;
  state_t      w_state_nxt;
  logic [15:0] w_cand_nxt;
  logic [7:0]  w_cnt_nxt;
  logic [15:0] w_stat;
  logic [15:0] w_ctrl;
  logic [15:0] w_rdata;
  logic        w_unused;

  team_id_sync #(.WIDTH(16)) u_sync (
    .clk   (mclk),
    .rst_n (puc_rst_n),
    .i_d   (team_id_in),
    .o_q   (w_raw)
  );

  // Address decode: upper word-address bits select the window, the low two
  // word-address bits pick one of the four registers.
  assign w_sel     = per.per_en & (per.per_addr[13:DEC_WD-1] == BASE_ADDR[14:DEC_WD]);
  assign w_rd      = w_sel & ~|per.per_we;
  assign w_wr_lo   = w_sel & per.per_we[0];
  assign w_idx     = per.per_addr[1:0];
  assign w_busy    = (r_state == ST_WAIT_STABLE);
  assign w_ctrl_wr = w_wr_lo & (w_idx == c_IDX_CTRL);
  assign w_chg_clr = w_wr_lo & (w_idx == c_IDX_STAT) & per.per_din[c_STAT_CHG];
  // A change is flagged on the first latch or whenever the latched value moves
  assign w_chg_set = w_latch & (~r_valid | (r_cand != r_id));
  assign irq       = r_chg & r_ctrl_ie;
  assign w_unused  = ^{per.per_din[15:2]};

  // FSM state register
  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, candidate and stability counter decisions
  always_comb begin
    w_state_nxt = r_state;
    w_cand_nxt  = r_cand;
    w_cnt_nxt   = r_cnt;
    w_latch     = 1'b0;
    if (!r_ctrl_en) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_WAIT_STABLE;
          w_cand_nxt  = w_raw;
          w_cnt_nxt   = 8'd0;
        end
        ST_WAIT_STABLE: begin
          if (smclk_en) begin
            if (w_raw != r_cand) begin
              w_cand_nxt = w_raw;
              w_cnt_nxt  = 8'd0;
            end else if (r_cnt == c_CNT_LAST) begin
              w_latch     = 1'b1;
              w_state_nxt = ST_LOCKED;
            end else if (r_cnt != 8'hFF) begin
              w_cnt_nxt = r_cnt + 8'd1;
            end
          end
        end
        ST_LOCKED: begin
          if (smclk_en && (w_raw != r_id)) begin
            w_state_nxt = ST_WAIT_STABLE;
            w_cand_nxt  = w_raw;
            w_cnt_nxt   = 8'd0;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 8'd0;
        end
      endcase
    end
  end

  // Debounce datapath, latched ID and status flags
  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      r_cand  <= 16'h0;
      r_cnt   <= 8'd0;
      r_id    <= 16'h0;
      r_valid <= 1'b0;
      r_chg   <= 1'b0;
    end else begin
      r_cand <= w_cand_nxt;
      r_cnt  <= w_cnt_nxt;
      if (w_latch) begin
        r_id    <= r_cand;
        r_valid <= 1'b1;
      end
      // Setting a new change wins over a simultaneous software clear
      if (w_chg_set) begin
        r_chg <= 1'b1;
      end else if (w_chg_clr) begin
        r_chg <= 1'b0;
      end
    end
  end

  // Software-controlled CTRL register (low byte lane only)
  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      r_ctrl_en <= 1'b0;
      r_ctrl_ie <= 1'b0;
    end else if (w_ctrl_wr) begin
      r_ctrl_en <= per.per_din[c_CTRL_EN];
      r_ctrl_ie <= per.per_din[c_CTRL_IE];
    end
  end

  // Assemble STAT/CTRL views and the combinational read mux
  always_comb begin
    w_stat               = 16'h0;
    w_stat[c_STAT_VALID] = r_valid;
    w_stat[c_STAT_CHG]   = r_chg;
    w_stat[c_STAT_BUSY]  = w_busy;
    w_ctrl               = 16'h0;
    w_ctrl[c_CTRL_EN]    = r_ctrl_en;
    w_ctrl[c_CTRL_IE]    = r_ctrl_ie;
    w_rdata              = 16'h0;
    if (w_rd) begin
      case (w_idx)
        c_IDX_ID:   w_rdata = r_id;
        c_IDX_STAT: w_rdata = w_stat;
        c_IDX_CTRL: w_rdata = w_ctrl;
        c_IDX_RAW:  w_rdata = w_raw;
        default:    w_rdata = 16'h0;
      endcase
    end
  end

  assign per.per_dout = w_rdata;

endmodule
`default_nettype wire

// File: tb/tb_team_id_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_team_id_reader
// Purpose  : Self-checking bench for team_id_reader (scoreboard on reads).
// Revision : 1.0 - initial release
// ============================================================================
module tb_team_id_reader;

  localparam logic [13:0] c_BASE_W = 14'h00DC;  // 15'h01B8 as a word address

  logic        mclk = 1'b0;
  logic        puc_rst_n = 1'b0;
  logic        smclk_en = 1'b1;
  logic [15:0] team_id_in = 16'h0;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_q[$];
  string       tag_q[$];

  team_id_reader_if per();

  team_id_reader #(
    .BASE_ADDR  (15'h01B8),
    .DEC_WD     (3),
    .STABLE_CNT (4)
  ) dut (
    .mclk       (mclk),
    .puc_rst_n  (puc_rst_n),
    .per        (per),
    .smclk_en   (smclk_en),
    .team_id_in (team_id_in),
    .irq        (irq)
  );

  always #5 mclk = ~mclk;

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] idx, input logic [15:0] d, input logic [1:0] we);
    @(negedge mclk);
    per.per_en   = 1'b1;
    per.per_addr = c_BASE_W + 14'(idx);
    per.per_din  = d;
    per.per_we   = we;
    @(posedge mclk);
    #1;
    per.per_en = 1'b0;
    per.per_we = 2'b00;
  endtask

  task automatic bus_read_addr(input logic [13:0] a, input logic [15:0] exp, input string tag);
    @(negedge mclk);
    per.per_en   = 1'b1;
    per.per_we   = 2'b00;
    per.per_addr = a;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    #1;
    check_val(tag_q.pop_front(), per.per_dout, exp_q.pop_front());
    per.per_en = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] idx, input logic [15:0] exp, input string tag);
    bus_read_addr(c_BASE_W + 14'(idx), exp, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    per.per_en   = 1'b0;
    per.per_we   = 2'b00;
    per.per_addr = 14'h0;
    per.per_din  = 16'h0;
    team_id_in   = 16'h00A5;

    // Reset state
    repeat (2) @(negedge mclk);
    check_val("rst_irq", {15'b0, irq}, 16'h0);
    bus_read(2'd0, 16'h0000, "rst_id");
    bus_read(2'd1, 16'h0000, "rst_stat");
    bus_read(2'd2, 16'h0000, "rst_ctrl");
    bus_read(2'd3, 16'h0000, "rst_raw");
    @(negedge mclk);
    puc_rst_n = 1'b1;
    repeat (3) @(negedge mclk);
    bus_read(2'd3, 16'h00A5, "raw_sync");

    // Enable with IE: first latch after STABLE_CNT+1 edges
    bus_write(2'd2, 16'h0003, 2'b11);
    bus_read(2'd2, 16'h0003, "ctrl_rb");
    for (int k = 0; k < 3; k++) bus_read(2'd1, 16'h0004, "stat_busy");
    bus_read(2'd0, 16'h0000, "id_prelatch");
    bus_read(2'd1, 16'h0003, "stat_latched");
    bus_read(2'd0, 16'h00A5, "id_latched");
    check_val("irq_first", {15'b0, irq}, 16'h1);

    // W1C of CHG, then exact STABLE_CNT+3 latency from an input change
    bus_write(2'd1, 16'h0002, 2'b01);
    bus_read(2'd1, 16'h0001, "stat_w1c");
    check_val("irq_cleared", {15'b0, irq}, 16'h0);
    @(negedge mclk);
    team_id_in = 16'h5A5A;
    for (int k = 1; k <= 7; k++)
      bus_read(2'd0, (k == 7) ? 16'h5A5A : 16'h00A5, "id_latency");
    bus_read(2'd1, 16'h0003, "stat_chg_new");
    check_val("irq_new", {15'b0, irq}, 16'h1);

    // Two-cycle glitch must not reach ID or raise CHG
    bus_write(2'd1, 16'h0002, 2'b01);
    @(negedge mclk);
    team_id_in = 16'h1234;
    bus_read(2'd1, 16'h0001, "glitch_e1");
    @(negedge mclk);
    team_id_in = 16'h5A5A;
    bus_read(2'd1, 16'h0005, "glitch_busy");
    bus_read(2'd0, 16'h5A5A, "glitch_id_mid");
    repeat (8) @(negedge mclk);
    bus_read(2'd0, 16'h5A5A, "glitch_id_end");
    bus_read(2'd1, 16'h0001, "glitch_no_chg");
    check_val("glitch_irq", {15'b0, irq}, 16'h0);

    // CHG clear on the very edge a new ID latches: set wins
    @(negedge mclk);
    team_id_in = 16'h0F0F;
    repeat (5) @(negedge mclk);
    bus_write(2'd1, 16'h0002, 2'b01);
    bus_read(2'd1, 16'h0003, "chg_set_wins");
    bus_read(2'd0, 16'h0F0F, "id_0f0f");

    // smclk_en freeze mid-count, then resume for the remaining ticks
    bus_write(2'd1, 16'h0002, 2'b01);
    @(negedge mclk);
    team_id_in = 16'h3C3C;
    repeat (4) @(negedge mclk);
    smclk_en = 1'b0;
    repeat (10) @(negedge mclk);
    bus_read(2'd1, 16'h0005, "freeze_stat");
    bus_read(2'd0, 16'h0F0F, "freeze_id");
    @(negedge mclk);
    smclk_en = 1'b1;
    bus_read(2'd0, 16'h0F0F, "resume_id_1");
    bus_read(2'd0, 16'h0F0F, "resume_id_2");
    bus_read(2'd0, 16'h3C3C, "resume_id_3");
    bus_read(2'd1, 16'h0003, "resume_stat");

    // High-lane-only CTRL write, unselected read, read-only ID
    bus_write(2'd2, 16'h0000, 2'b10);
    bus_read(2'd2, 16'h0003, "ctrl_we_hi");
    bus_read_addr(14'h00E0, 16'h0000, "unsel_read");
    bus_write(2'd0, 16'hFFFF, 2'b11);
    bus_read(2'd0, 16'h3C3C, "id_ro");

    // Clearing EN during WAIT_STABLE returns to IDLE, flags retained
    @(negedge mclk);
    team_id_in = 16'h1111;
    repeat (4) @(negedge mclk);
    bus_write(2'd2, 16'h0002, 2'b11);
    bus_read(2'd1, 16'h0007, "en_clr_same");
    bus_read(2'd1, 16'h0003, "en_clr_idle");
    repeat (8) @(negedge mclk);
    bus_read(2'd0, 16'h3C3C, "en_clr_id_kept");
    check_val("en_clr_irq", {15'b0, irq}, 16'h1);

    // Reset in WAIT_STABLE clears everything and restarts from IDLE
    bus_write(2'd2, 16'h0003, 2'b11);
    repeat (2) @(negedge mclk);
    bus_read(2'd1, 16'h0007, "busy_before_rst");
    @(negedge mclk);
    puc_rst_n = 1'b0;
    #1;
    check_val("mid_rst_irq", {15'b0, irq}, 16'h0);
    bus_read(2'd0, 16'h0000, "mid_rst_id");
    bus_read(2'd1, 16'h0000, "mid_rst_stat");
    bus_read(2'd2, 16'h0000, "mid_rst_ctrl");
    bus_read(2'd3, 16'h0000, "mid_rst_raw");
    @(negedge mclk);
    puc_rst_n = 1'b1;
    repeat (5) @(negedge mclk);
    bus_read(2'd1, 16'h0000, "post_rst_idle");
    bus_read(2'd3, 16'h1111, "post_rst_raw");
    bus_read(2'd0, 16'h0000, "post_rst_id");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/team_id_reader.md
TEAM_ID_READER -- requirements
Module: team_id_reader

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 15'h01B8, byte base address of the 4-register window (aligned to 8 bytes).
REQ-002 SHALL have parameter DEC_WD, default 3, address decoder bit width.
REQ-003 SHALL have parameter STABLE_CNT, default 4, legal range 1..255: smclk_en ticks a sample must hold before latch.
REQ-004 mclk  in  1  single system clock; all state on rising edge.
REQ-005 puc_rst_n  in  1  reset, asynchronous, active-low.
REQ-006 per_addr  in  14  peripheral word address.
REQ-007 per_din  in  16  peripheral write data.
REQ-008 per_en  in  1  peripheral enable, active high.
REQ-009 per_we  in  2  byte write enables, active high.
REQ-010 smclk_en  in  1  sample tick qualifier.
REQ-011 team_id_in  in  16  team ID bus driven by the radio-side writer register.
REQ-012 per_dout  out  16  read data; 16'h0 when not selected or not reading.
REQ-013 irq  out  1  change interrupt, level, = STAT.CHG & CTRL.IE.

Function
REQ-014 Register map (byte offset): 0x0 ID (RO, latched ID); 0x2 STAT (bit0 VALID RO, bit1 CHG W1C, bit2 BUSY RO, others 0); 0x4 CTRL (bit0 EN, bit1 IE, RW, others 0); 0x6 RAW (RO, synchronized sample).
REQ-015 Selection SHALL be per_en & per_addr[13:DEC_WD-1]==BASE_ADDR[14:DEC_WD]; read = ~|per_we, write = |per_we.
REQ-016 CTRL/STAT writes SHALL take effect only when per_we[0]=1; writes to ID/RAW SHALL be ignored.
REQ-017 Reads SHALL be combinational (same cycle as per_en).
REQ-018 team_id_in SHALL pass through a 2-flop synchronizer; RAW = second stage.
REQ-019 FSM states: IDLE, WAIT_STABLE, LOCKED.
REQ-020 IDLE: BUSY=0, counter held 0; on EN=1 -> WAIT_STABLE with candidate <= RAW, cnt <= 0.
REQ-021 WAIT_STABLE, smclk_en=1: RAW!=candidate -> candidate <= RAW, cnt <= 0; else cnt==STABLE_CNT-1 -> latch and go LOCKED; else cnt++.
REQ-022 Latch: ID <= candidate, VALID <= 1; CHG <= 1 if VALID was 0 or candidate != previous ID.
REQ-023 LOCKED, smclk_en=1, RAW!=ID -> WAIT_STABLE, candidate <= RAW, cnt <= 0.
REQ-024 smclk_en=0 SHALL freeze FSM, cnt and candidate (synchronizer keeps running).
REQ-025 BUSY SHALL be 1 exactly in WAIT_STABLE.
REQ-026 EN cleared in any state -> IDLE next cycle; ID, VALID, CHG retained.
REQ-027 Latency: with smclk_en=1 and EN=1, ID reflects a new stable input exactly STABLE_CNT+3 mclk edges after team_id_in changes.
REQ-028 A glitch shorter than STABLE_CNT ticks SHALL never reach ID.
REQ-029 Simultaneous CHG set and CHG W1C in one cycle: set wins.
REQ-030 Counter SHALL be 8 bits and never wrap.

Reset
REQ-031 puc_rst_n=0 SHALL asynchronously clear: synchronizer, candidate, cnt, ID=16'h0, VALID=0, CHG=0, CTRL=0, FSM=IDLE.
REQ-032 During reset per_dout=16'h0, irq=0.
REQ-033 Reset deassertion mid-operation SHALL resume only from IDLE; no partial latch.

Structure
REQ-034 Register offsets, STAT/CTRL bit indices and FSM state encoding SHALL live in shared package team_id_pkg.
REQ-035 Sub-module team_id_sync (2-flop, 16-bit, async active-low reset) SHALL be instantiated once; the rest stays flat.

Verification
REQ-036 Reset, EN=1, team_id_in=16'h00A5 held, STABLE_CNT=4 -> ID=16'h00A5, VALID=1, CHG=1 at edge 7; irq=1 only if IE=1.
REQ-037 Locked at 16'h00A5, pulse team_id_in=16'h1234 for 2 cycles -> BUSY=1 briefly, ID stays 16'h00A5, CHG not set.
REQ-038 Write STAT=16'h0002 on the same cycle a new ID latches -> CHG remains 1.
REQ-039 smclk_en held 0 with input change -> ID unchanged, cnt frozen; smclk_en=1 resumes and latches after remaining ticks.
REQ-040 Assert puc_rst_n=0 during WAIT_STABLE -> all registers 0, FSM IDLE; per_dout=0 on ID read.
REQ-041 Write CTRL with per_we=2'b10 -> CTRL unchanged; read of unselected address -> per_dout=16'h0.
